// File: rtl/seg_scan_monitor.sv
// Receive-side monitor for a 6-digit multiplexed 7-segment bus.
// Captures each digit once stable, decodes it, and presents full frames on valid/ready.
module seg_scan_monitor #(
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  seg_sel,
    input  logic [7:0]  seg_data,
    output logic        frame_valid,
    input  logic        frame_ready,
    output logic [23:0] frame_digits,
    output logic [5:0]  frame_dp,
    output logic [5:0]  frame_err,
    output logic        scan_lost,
    output logic [7:0]  overrun_cnt
);

    localparam int unsigned NSLOT = 6;
    localparam int unsigned CNT_W = 32;

    typedef enum logic [1:0] {WAIT_SEL, SETTLE, HOLD} state_t;

    state_t                 state_q, state_d;
    logic [NSLOT-1:0]       sel_q, sel_d;
    logic [7:0]             data_q, data_d;
    logic [CNT_W-1:0]       stable_q, stable_d;
    logic [CNT_W-1:0]       idle_q, idle_d;
    logic [NSLOT-1:0]       mask_q, mask_d;
    logic [4*NSLOT-1:0]     buf_dig_q, buf_dig_d;
    logic [NSLOT-1:0]       buf_dp_q, buf_dp_d;
    logic [NSLOT-1:0]       buf_err_q, buf_err_d;
    logic [4*NSLOT-1:0]     fr_dig_q, fr_dig_d;
    logic [NSLOT-1:0]       fr_dp_q, fr_dp_d;
    logic [NSLOT-1:0]       fr_err_q, fr_err_d;
    logic                   fr_valid_q, fr_valid_d;
    logic                   lost_q, lost_d;
    logic [7:0]             ovr_q, ovr_d;

    logic                   capture;
    logic                   start;
    logic                   changed;
    logic                   legal;
    logic [2:0]             cap_slot;
    logic [4:0]             dec;
    logic                   complete;
    logic                   accept;
    logic                   load;

    // Exactly one select line low.
    function automatic logic sel_legal(input logic [5:0] sel);
        logic [5:0] n;
        n = ~sel;
        return (n != 6'd0) && ((n & (n - 6'd1)) == 6'd0);
    endfunction

    // Index of the low select bit.
    function automatic logic [2:0] sel_slot(input logic [5:0] sel);
        logic [2:0] s;
        s = 3'd0;
        for (int i = 0; i < 6; i++) begin
            if (!sel[i]) s = 3'(i);
        end
        return s;
    endfunction

    // Segment pattern to {err, value}.
    function automatic logic [4:0] seg_decode(input logic [6:0] p);
        logic [4:0] r;
        case (p)
            7'h40:   r = 5'h00;
            7'h79:   r = 5'h01;
            7'h24:   r = 5'h02;
            7'h30:   r = 5'h03;
            7'h19:   r = 5'h04;
            7'h12:   r = 5'h05;
            7'h02:   r = 5'h06;
            7'h78:   r = 5'h07;
            7'h00:   r = 5'h08;
            7'h10:   r = 5'h09;
            default: r = 5'h1F;
        endcase
        return r;
    endfunction

    assign changed  = (seg_sel != sel_q) || (seg_data != data_q);
    assign legal    = sel_legal(seg_sel);
    assign cap_slot = sel_slot(seg_sel);
    assign dec      = seg_decode(seg_data[6:0]);

    // Settle FSM: decide when the current digit is stable enough to capture.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        data_d   = data_q;
        stable_d = stable_q;
        capture  = 1'b0;
        start    = 1'b0;
        case (state_q)
            WAIT_SEL: begin
                if (legal) start = 1'b1;
            end
            SETTLE: begin
                if (!changed) begin
                    if (stable_q + 32'd1 >= 32'(SETTLE_CYCLES)) begin
                        capture = 1'b1;
                        state_d = HOLD;
                    end
                    stable_d = stable_q + 32'd1;
                end else if (legal) begin
                    start = 1'b1;
                end else begin
                    state_d = WAIT_SEL;
                end
            end
            HOLD: begin
                if (changed) begin
                    if (legal) start   = 1'b1;
                    else       state_d = WAIT_SEL;
                end
            end
            default: state_d = WAIT_SEL;
        endcase
        if (start) begin
            sel_d    = seg_sel;
            data_d   = seg_data;
            stable_d = 32'd1;
            if (SETTLE_CYCLES <= 1) begin
                capture = 1'b1;
                state_d = HOLD;
            end else begin
                state_d = SETTLE;
            end
        end
    end

    assign complete = (mask_q == 6'h3F);
    assign accept   = fr_valid_q & frame_ready;
    assign load     = complete & (~fr_valid_q | accept);

    // Capture buffer, frame hand-off and scan timeout.
    always_comb begin
        mask_d     = complete ? 6'd0 : mask_q;
        buf_dig_d  = buf_dig_q;
        buf_dp_d   = buf_dp_q;
        buf_err_d  = buf_err_q;
        fr_dig_d   = fr_dig_q;
        fr_dp_d    = fr_dp_q;
        fr_err_d   = fr_err_q;
        fr_valid_d = fr_valid_q;
        lost_d     = lost_q;
        idle_d     = idle_q;
        ovr_d      = ovr_q;

        if (accept) fr_valid_d = 1'b0;
        if (load) begin
            fr_dig_d   = buf_dig_q;
            fr_dp_d    = buf_dp_q;
            fr_err_d   = buf_err_q;
            fr_valid_d = 1'b1;
        end else if (complete && (ovr_q != 8'hFF)) begin
            ovr_d = ovr_q + 8'd1;
        end

        if (capture) begin
            idle_d = '0;
            lost_d = 1'b0;
        end else if (idle_q != 32'(TIMEOUT_CYCLES)) begin
            idle_d = idle_q + 32'd1;
            if (idle_q + 32'd1 == 32'(TIMEOUT_CYCLES)) begin
                lost_d = 1'b1;
                mask_d = '0;
            end
        end

        if (capture) begin
            mask_d[cap_slot]                 = 1'b1;
            buf_dig_d[{cap_slot, 2'b00} +: 4] = dec[3:0];
            buf_dp_d[cap_slot]               = ~seg_data[7];
            buf_err_d[cap_slot]              = dec[4];
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= WAIT_SEL;
            sel_q      <= '1;
            data_q     <= '0;
            stable_q   <= '0;
            idle_q     <= '0;
            mask_q     <= '0;
            buf_dig_q  <= '0;
            buf_dp_q   <= '0;
            buf_err_q  <= '0;
            fr_dig_q   <= '0;
            fr_dp_q    <= '0;
            fr_err_q   <= '0;
            fr_valid_q <= 1'b0;
            lost_q     <= 1'b0;
            ovr_q      <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            data_q     <= data_d;
            stable_q   <= stable_d;
            idle_q     <= idle_d;
            mask_q     <= mask_d;
            buf_dig_q  <= buf_dig_d;
            buf_dp_q   <= buf_dp_d;
            buf_err_q  <= buf_err_d;
            fr_dig_q   <= fr_dig_d;
            fr_dp_q    <= fr_dp_d;
            fr_err_q   <= fr_err_d;
            fr_valid_q <= fr_valid_d;
            lost_q     <= lost_d;
            ovr_q      <= ovr_d;
        end
    end

    assign frame_valid  = fr_valid_q;
    assign frame_digits = fr_dig_q;
    assign frame_dp     = fr_dp_q;
    assign frame_err    = fr_err_q;
    assign scan_lost    = lost_q;
    assign overrun_cnt  = ovr_q;

endmodule

// File: tb/tb_seg_scan_monitor.sv
// Directed bench for seg_scan_monitor with hand-computed expected frames.
module tb_seg_scan_monitor;

    localparam int unsigned SETTLE = 4;
    localparam int unsigned TO     = 50;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  seg_sel;
    logic [7:0]  seg_data;
    logic        frame_valid;
    logic        frame_ready;
    logic [23:0] frame_digits;
    logic [5:0]  frame_dp;
    logic [5:0]  frame_err;
    logic        scan_lost;
    logic [7:0]  overrun_cnt;

    int total = 0;
    int bad   = 0;

    logic [6:0] pat [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                             7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    seg_scan_monitor #(.SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .seg_sel      (seg_sel),
        .seg_data     (seg_data),
        .frame_valid  (frame_valid),
        .frame_ready  (frame_ready),
        .frame_digits (frame_digits),
        .frame_dp     (frame_dp),
        .frame_err    (frame_err),
        .scan_lost    (scan_lost),
        .overrun_cnt  (overrun_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] seg(input int d);
        return {1'b1, pat[d]};
    endfunction

    function automatic logic [5:0] sel_of(input int s);
        logic [5:0] m;
        m    = 6'h3F;
        m[s] = 1'b0;
        return m;
    endfunction

    // Drive the bus and let n rising edges sample it; returns on a falling edge.
    task automatic hold(input logic [5:0] s, input logic [7:0] d, input int n);
        seg_sel  = s;
        seg_data = d;
        repeat (n) @(negedge clk);
    endtask

    task automatic slot(input int s, input int digit, input int n);
        hold(sel_of(s), seg(digit), n);
    endtask

    task automatic scan6(input logic [23:0] v, input int dwell);
        for (int i = 0; i < 6; i++) slot(i, int'(v[4*i +: 4]), dwell);
    endtask

    task automatic consume(input string tag);
        frame_ready = 1'b1;
        @(negedge clk);
        frame_ready = 1'b0;
        chk(tag, 32'(frame_valid), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        frame_ready = 1'b0;
        seg_sel     = 6'h3F;
        seg_data    = 8'hFF;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(frame_valid), 32'd0);
        chk("rst_digits", 32'(frame_digits), 32'd0);
        chk("rst_lost", 32'(scan_lost), 32'd0);
        chk("rst_ovr", 32'(overrun_cnt), 32'd0);
        rst_n = 1'b1;

        // Clean scan and one-clock completion latency.
        for (int i = 0; i < 5; i++) slot(i, i + 1, 6);
        slot(5, 6, 4);
        chk("t1_not_yet", 32'(frame_valid), 32'd0);
        slot(5, 6, 1);
        chk("t1_valid", 32'(frame_valid), 32'd1);
        chk("t1_digits", 32'(frame_digits), 32'h654321);
        chk("t1_dp", 32'(frame_dp), 32'd0);
        chk("t1_err", 32'(frame_err), 32'd0);
        consume("t1_consume");
        hold(6'h3F, 8'hFF, 2);

        // Decimal point and illegal pattern.
        slot(0, 1, 6);
        hold(sel_of(1), 8'hFF, 6);
        slot(2, 3, 6);
        hold(sel_of(3), 8'h40, 6);
        slot(4, 5, 6);
        slot(5, 6, 6);
        chk("t2_valid", 32'(frame_valid), 32'd1);
        chk("t2_digits", 32'(frame_digits), 32'h6503F1);
        chk("t2_dp", 32'(frame_dp), 32'b001000);
        chk("t2_err", 32'(frame_err), 32'b000010);
        consume("t2_consume");

        // Short dwell and glitch do not capture; stable dwell does.
        slot(0, 9, 3);
        for (int i = 1; i < 6; i++) slot(i, i + 1, 6);
        hold(6'h3F, 8'hFF, 2);
        chk("t3_short", 32'(frame_valid), 32'd0);
        slot(0, 8, 2);
        slot(0, 9, 1);
        slot(0, 8, 2);
        hold(6'h3F, 8'hFF, 2);
        chk("t3_glitch", 32'(frame_valid), 32'd0);
        slot(0, 7, 4);
        hold(6'h3F, 8'hFF, 1);
        chk("t3_valid", 32'(frame_valid), 32'd1);
        chk("t3_digits", 32'(frame_digits), 32'h654327);
        consume("t3_consume");
        for (int i = 0; i < 5; i++) slot(i, i + 1, 6);
        slot(5, 6, 20);
        chk("t3_long_valid", 32'(frame_valid), 32'd1);
        consume("t3_long_consume");
        for (int i = 0; i < 5; i++) slot(i, i + 1, 6);
        hold(6'h3F, 8'hFF, 2);
        chk("t3_once", 32'(frame_valid), 32'd0);

        // Backpressure: later frames dropped, first held.
        scan6(24'h654321, 6);
        chk("t4_first", 32'(frame_valid), 32'd1);
        scan6(24'h777777, 6);
        chk("t4_ovr1", 32'(overrun_cnt), 32'd1);
        chk("t4_hold1", 32'(frame_digits), 32'h654321);
        scan6(24'h888888, 6);
        chk("t4_ovr2", 32'(overrun_cnt), 32'd2);
        chk("t4_hold2", 32'(frame_digits), 32'h654321);
        chk("t4_still", 32'(frame_valid), 32'd1);
        consume("t4_consume");

        // Timeout with a partial frame pending.
        for (int i = 3; i < 6; i++) slot(i, 9, 6);
        hold(6'h3F, 8'hFF, TO - 3);
        chk("t5_before", 32'(scan_lost), 32'd0);
        hold(6'h3F, 8'hFF, 1);
        chk("t5_lost", 32'(scan_lost), 32'd1);
        hold(6'h3C, 8'hFF, 10);
        chk("t5_lost_multi", 32'(scan_lost), 32'd1);
        slot(0, 1, 3);
        chk("t5_lost_pre", 32'(scan_lost), 32'd1);
        slot(0, 1, 1);
        chk("t5_recover", 32'(scan_lost), 32'd0);
        slot(0, 1, 2);
        slot(1, 2, 6);
        slot(2, 3, 6);
        hold(6'h3F, 8'hFF, 2);
        chk("t5_mask", 32'(frame_valid), 32'd0);
        for (int i = 3; i < 6; i++) slot(i, i + 1, 6);
        chk("t5_valid", 32'(frame_valid), 32'd1);
        chk("t5_digits", 32'(frame_digits), 32'h654321);

        // Reset mid-frame with a pending frame and nonzero overrun.
        for (int i = 0; i < 4; i++) slot(i, 9, 6);
        rst_n   = 1'b0;
        seg_sel = 6'h3F;
        #1;
        chk("t6_valid", 32'(frame_valid), 32'd0);
        chk("t6_digits", 32'(frame_digits), 32'd0);
        chk("t6_ovr", 32'(overrun_cnt), 32'd0);
        chk("t6_dp_err", 32'({frame_dp, frame_err}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        slot(4, 5, 6);
        slot(5, 6, 6);
        hold(6'h3F, 8'hFF, 2);
        chk("t6_partial", 32'(frame_valid), 32'd0);
        for (int i = 0; i < 4; i++) slot(i, i + 1, 6);
        chk("t6_frame", 32'(frame_valid), 32'd1);
        chk("t6_frame_digits", 32'(frame_digits), 32'h654321);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
